aux_run_controller: RTL
=======================

Name: aux_run_controller

Overview:
- Run/stop sequencer for the CPU core.
- Drives the core enable from the core clock domain and stops the core on a syscall halt, on a PC breakpoint, or after N single-step cycles.
- Restarts the core on a debounced resume button press.
- Sits between the board buttons and switches and the core; its `en` feeds the core and every statistics counter enable.

Parameters:
- DbCycles, 4: number of consecutive core-clock samples the synchronized resume level must hold before it is accepted.
- StepBits, 8: width of the step-count input and of the internal step counter.

Ports:
- clk  input  1  core clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- resume  input  1  raw resume push-button level, asynchronous to clk
- step_mode  input  1  switch level; 1 = resume enters stepping, 0 = resume enters free run
- step_cnt  input  StepBits  cycles per step burst; 0 is treated as 1
- halt  input  1  core syscall-halt request, combinational from the current instruction
- pc  input  32  current core PC
- bkpt_addr  input  32  breakpoint address
- bkpt_valid  input  1  breakpoint armed
- en  output  1  core/counter enable (combinational)
- stopped  output  1  1 while in HALTED
- stop_cause  output  2  0 none, 1 syscall, 2 breakpoint, 3 step done
- step_left  output  StepBits  remaining cycles in the current step burst, 0 outside STEP

Behaviour:
- Reset (async, rst_n=0):
  - state=RUN, stop_cause=0, step_left=0, skip=1.
  - Sync/debounce flops and counters clear.
  - en may be 1 immediately after rst_n rises.
- Resume input path:
  - 2-flop synchronizer.
  - Stable counter: the debounced level updates after DbCycles equal consecutive samples.
  - resume_pulse is a 1-cycle pulse on the debounced 0->1 edge.
  - Press-to-pulse latency is 2+DbCycles cycles.
- stop_req = `!skip && (halt || (bkpt_valid && pc==bkpt_addr))`.
- en = `(state==RUN || state==STEP) && !stop_req`. A stopping instruction never commits.
- skip: set on reset and on leaving HALTED; cleared after the first cycle with en=1. Resuming therefore executes past the instruction that caused the stop.
- State RUN:
  - stop_req -> HALTED next cycle.
  - stop_cause = 1 if halt, else 2. Syscall has priority when both are true.
- State STEP:
  - Entered with step_left = max(step_cnt,1).
  - Each en=1 cycle decrements step_left.
  - When en=1 and step_left==1 -> HALTED, stop_cause=3, step_left=0.
  - stop_req has priority over step completion: HALTED with cause 1/2, step_left cleared.
- State HALTED:
  - en=0, stopped=1, stop_cause held.
  - resume_pulse -> STEP if step_mode=1, else RUN; stop_cause cleared to 0; skip=1.
- resume_pulse in RUN or STEP is ignored. Changes to step_mode or step_cnt take effect only at the next resume.
- Reset mid-burst or while HALTED aborts immediately to the reset values.

Optional Feature:
- AUX_RUN_BKPT_EN defined: breakpoint comparison is active as above.
- AUX_RUN_BKPT_EN undefined:
  - pc, bkpt_addr and bkpt_valid are ignored (ports remain).
  - stop_req = `!skip && halt`.
  - stop_cause never equals 2.
  - The comparator logic is removed.

Test Plan:
- Syscall stop:
  - Reset, then assert halt at cycle 10 held high -> en=0 from cycle 10; stopped=1, stop_cause=1 from cycle 11.
  - Press resume -> RUN after 2+4 cycles; en=1 for one cycle despite halt=1; then re-stop with cause 1.
- Breakpoint: bkpt_valid=1, bkpt_addr=0x0000_0040, pc steps by 4 -> en=0 when pc=0x40; stop_cause=2. Resume -> pc=0x40 commits, run continues.
- Step burst:
  - step_mode=1, step_cnt=3, resume from HALTED -> exactly 3 cycles with en=1; step_left 3,2,1; then stopped=1, stop_cause=3.
  - step_cnt=0 -> exactly 1 en cycle.
- Debounce: resume glitch high for 2 cycles -> no transition. Held for 8 cycles -> exactly one resume_pulse and one transition.
- Priority and reset:
  - During STEP with step_left=1, halt=1 -> HALTED with cause 1, not 3.
  - rst_n low mid-STEP -> state RUN, step_left=0, stop_cause=0 asynchronously.
- Macro: build without AUX_RUN_BKPT_EN, pc==bkpt_addr with bkpt_valid=1 -> en stays 1, no stop.

Source files
------------

// File: rtl/aux_run_controller.sv
// aux_run_controller: run/stop sequencer for the CPU core.
// Gates the core enable, stops on syscall halt, PC breakpoint or step-burst
// completion, and restarts on a debounced resume button press.
// Optional feature macro: AUX_RUN_BKPT_EN enables the PC breakpoint comparator.
module aux_run_controller #(
    parameter int unsigned DbCycles = 4,
    parameter int unsigned StepBits = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                resume,
    input  logic                step_mode,
    input  logic [StepBits-1:0] step_cnt,
    input  logic                halt,
    input  logic [31:0]         pc,
    input  logic [31:0]         bkpt_addr,
    input  logic                bkpt_valid,
    output logic                en,
    output logic                stopped,
    output logic [1:0]          stop_cause,
    output logic [StepBits-1:0] step_left
);

    typedef enum logic [1:0] {StRun, StStep, StHalted} state_e;

    localparam logic [1:0] CauseNone    = 2'd0;
    localparam logic [1:0] CauseSyscall = 2'd1;
    localparam logic [1:0] CauseBkpt    = 2'd2;
    localparam logic [1:0] CauseStep    = 2'd3;

    localparam int unsigned CntW = $clog2(DbCycles + 1);

    // ---------------- resume synchronizer and debounce ----------------
    logic            sync1_q, sync2_q;
    logic            db_q;
    logic [CntW-1:0] db_cnt_q;
    logic            db_differ;
    logic            db_accept;
    logic            resume_pulse;

    // Two-flop synchronizer for the asynchronous button level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= resume;
            sync2_q <= sync1_q;
        end
    end

    // The DbCycles-th consecutive sample that disagrees with the debounced level flips it.
    assign db_differ    = (sync2_q != db_q);
    assign db_accept    = db_differ && (db_cnt_q == CntW'(DbCycles - 1));
    assign resume_pulse = db_accept && sync2_q;

    // Stable counter and debounced level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_q     <= 1'b0;
            db_cnt_q <= '0;
        end else if (!db_differ) begin
            db_cnt_q <= '0;
        end else if (db_accept) begin
            db_q     <= sync2_q;
            db_cnt_q <= '0;
        end else begin
            db_cnt_q <= db_cnt_q + 1'b1;
        end
    end

    // ---------------- stop request ----------------
    logic skip_q, skip_d;
    logic bkpt_hit;
    logic stop_req;

`ifdef AUX_RUN_BKPT_EN
    assign bkpt_hit = bkpt_valid && (pc == bkpt_addr);
`else
    logic unused_bkpt;
    assign unused_bkpt = ^{pc, bkpt_addr, bkpt_valid};
    assign bkpt_hit    = 1'b0;
`endif

    // skip lets the instruction that caused the stop commit once after a resume.
    assign stop_req = !skip_q && (halt || bkpt_hit);

    // ---------------- run/step/halt FSM ----------------
    state_e              state_q, state_d;
    logic [1:0]          cause_q, cause_d;
    logic [StepBits-1:0] left_q, left_d;

    // State register; reset lands in RUN with skip set so the core starts at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
            cause_q <= CauseNone;
            left_q  <= '0;
            skip_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            left_q  <= left_d;
            skip_q  <= skip_d;
        end
    end

    // Next-state and enable: a stopping instruction is blocked in the same cycle.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        left_d  = left_q;
        skip_d  = skip_q;
        en      = 1'b0;

        unique case (state_q)
            StRun: begin
                if (stop_req) begin
                    state_d = StHalted;
                    cause_d = halt ? CauseSyscall : CauseBkpt;
                end else begin
                    en     = 1'b1;
                    skip_d = 1'b0;
                end
            end
            StStep: begin
                if (stop_req) begin
                    state_d = StHalted;
                    cause_d = halt ? CauseSyscall : CauseBkpt;
                    left_d  = '0;
                end else begin
                    en     = 1'b1;
                    skip_d = 1'b0;
                    if (left_q == StepBits'(1)) begin
                        state_d = StHalted;
                        cause_d = CauseStep;
                        left_d  = '0;
                    end else begin
                        left_d = left_q - 1'b1;
                    end
                end
            end
            StHalted: begin
                if (resume_pulse) begin
                    cause_d = CauseNone;
                    skip_d  = 1'b1;
                    if (step_mode) begin
                        state_d = StStep;
                        left_d  = (step_cnt == '0) ? StepBits'(1) : step_cnt;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    assign stopped    = (state_q == StHalted);
    assign stop_cause = cause_q;
    assign step_left  = left_q;

endmodule
